// File: rtl/i2s_slave_rx.sv
// rtl/i2s_slave_rx.sv - I2S slave receiver, synchronized to the system clock
//
// Samples an asynchronous I2S bus through two-flop synchronizers. It
// deserializes MSB-first left and right words and presents each complete
// stereo pair with a one-cycle valid strobe.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst_n      asynchronous active-low reset
//   sclk_in    I2S bit clock (asynchronous)
//   ws_in      I2S word select, 0 = left, 1 = right
//   sd_in      I2S serial data
//   rx_data_l  last complete left word
//   rx_data_r  last complete right word
//   rx_valid   one-cycle pulse, data updated in the same cycle
//   frame_err  one-cycle pulse on a short or long slot
//   locked     high while framing is tracked

module i2s_slave_rx #(
   parameter int WIDTH    = 8,
   parameter int MAX_SLOT = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk_in,
   input  logic             ws_in,
   input  logic             sd_in,
   output logic [WIDTH-1:0] rx_data_l,
   output logic [WIDTH-1:0] rx_data_r,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             locked
);

   localparam int SW = $clog2(MAX_SLOT + 1);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [SW-1:0] SLOT_MAX  = SW'(MAX_SLOT);
   localparam logic [SW-1:0] SLOT_LAST = SW'(MAX_SLOT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

   typedef enum logic [2:0] {LOCK, SHIFT_L, SHIFT_R, HOLD_L, HOLD_R} state_t;

   state_t           state;
   logic             sclk_q1, sclk_q2, sclk_q3;
   logic             ws_q1, ws_q2, sd_q1, sd_q2;
   logic             ws_prev;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] left_pending;
   logic [BW-1:0]    bit_cnt;
   logic [SW-1:0]    slot_cnt;
   logic             pair_ok;

   logic             sample_evt;
   logic             ws_trans;
   logic             shifting;
   logic             word_done;
   logic [WIDTH-1:0] shift_word;

   always_comb begin
      sample_evt = sclk_q2 & ~sclk_q3;
      ws_trans   = ws_q2 ^ ws_prev;
      shifting   = (state == SHIFT_L) || (state == SHIFT_R);
      // The bit at this event is the LSB: a transition now is a legal slot end.
      word_done  = shifting && (bit_cnt == BIT_LAST);
      shift_word = {word[WIDTH-2:0], sd_q2};
   end

   assign locked = (state != LOCK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOCK;
         sclk_q1      <= 1'b0;
         sclk_q2      <= 1'b0;
         sclk_q3      <= 1'b0;
         ws_q1        <= 1'b0;
         ws_q2        <= 1'b0;
         sd_q1        <= 1'b0;
         sd_q2        <= 1'b0;
         ws_prev      <= 1'b0;
         word         <= '0;
         left_pending <= '0;
         bit_cnt      <= '0;
         slot_cnt     <= '0;
         pair_ok      <= 1'b0;
         rx_data_l    <= '0;
         rx_data_r    <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         sclk_q1   <= sclk_in;
         sclk_q2   <= sclk_q1;
         sclk_q3   <= sclk_q2;
         ws_q1     <= ws_in;
         ws_q2     <= ws_q1;
         sd_q1     <= sd_in;
         sd_q2     <= sd_q1;

         if (sample_evt) begin
            ws_prev <= ws_q2;

            // The bit on this event belongs to the current slot, even when
            // ws has just flipped (one-bit I2S delay).
            if (shifting) begin
               word    <= shift_word;
               bit_cnt <= bit_cnt + 1'b1;
               if (word_done) begin
                  if (state == SHIFT_L) begin
                     left_pending <= shift_word;
                     pair_ok      <= 1'b1;
                     state        <= HOLD_L;
                  end else begin
                     if (pair_ok) begin
                        rx_data_l <= left_pending;
                        rx_data_r <= shift_word;
                        rx_valid  <= 1'b1;
                     end
                     pair_ok <= 1'b0;
                     state   <= HOLD_R;
                  end
               end
            end

            // Transition handling overrides the per-bit state updates above.
            if (ws_trans) begin
               slot_cnt <= '0;
               word     <= '0;
               bit_cnt  <= '0;
               if (state == LOCK) begin
                  if (!ws_q2) state <= SHIFT_L;
               end else begin
                  if (shifting && !word_done) begin
                     frame_err <= 1'b1;
                     pair_ok   <= 1'b0;
                  end
                  state <= ws_q2 ? SHIFT_R : SHIFT_L;
               end
            end else begin
               if (slot_cnt != SLOT_MAX) slot_cnt <= slot_cnt + 1'b1;
               if ((state != LOCK) && (slot_cnt == SLOT_LAST)) begin
                  frame_err <= 1'b1;
                  pair_ok   <= 1'b0;
                  word      <= '0;
                  bit_cnt   <= '0;
                  state     <= LOCK;
               end
            end
         end
      end
   end

endmodule
